// File: rtl/mux_n_arb_pkg.sv
// Shared definitions for the N-channel operand multiplexer/arbiter:
// index-width helper and selection-mode encodings.
package mux_pkg;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_RR     = 1'b1;

endpackage

// File: rtl/mux_n_arb_if.sv
// Handshake bundle between the operand sources, the mux/arbiter and its consumer.
interface mux_n_arb_if
  import mux_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NCH   = 8
);
  localparam int SELW = clog2(NCH);

  logic                  mode;
  logic [SELW-1:0]       ch;
  logic [NCH*WIDTH-1:0]  in_data;
  logic [NCH-1:0]        in_valid;
  logic [NCH-1:0]        in_ready;
  logic [WIDTH-1:0]      out_data;
  logic [SELW-1:0]       out_ch;
  logic                  out_valid;
  logic                  out_ready;

  modport slave (
    input  mode, ch, in_data, in_valid, out_ready,
    output in_ready, out_data, out_ch, out_valid
  );

  modport master (
    output mode, ch, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_ch, out_valid
  );

endinterface

// File: rtl/mux_n_arb_rr_arbiter.sv
// Round-robin arbiter: grants the first requester above the last granted
// channel (wrapping), and moves its pointer only when told a transfer happened.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter  int NCH  = 8,
  localparam int SELW = clog2(NCH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NCH-1:0]  req_i,
  input  logic            adv_i,
  output logic [NCH-1:0]  gnt_o,
  output logic [SELW-1:0] gnt_idx_o
);

  logic [SELW-1:0] ptr_q, ptr_d;
  logic            found;
  int unsigned     idx;

  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    idx       = 0;
    // Offsets 1..NCH visit every channel once, ending on the pointer itself.
    for (int i = 1; i <= NCH; i++) begin
      idx = (int'(ptr_q) + i) % NCH;
      if (!found && req_i[idx]) begin
        found        = 1'b1;
        gnt_o[idx]   = 1'b1;
        gnt_idx_o    = SELW'(idx);
      end
    end
    ptr_d = adv_i ? gnt_idx_o : ptr_q;
  end

  // Reset to the last channel so channel 0 wins the first arbitration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= SELW'(NCH - 1);
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/mux_n_arb.sv
// N-to-1 operand multiplexer with direct or round-robin selection,
// valid/ready on every input and a single registered output stage.
module mux_n_arb
  import mux_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NCH   = 8
) (
  input logic         clk,
  input logic         rst_n,
  mux_n_arb_if.slave  bus
);

  localparam int SELW = clog2(NCH);

  logic              load;
  logic [NCH-1:0]    rdy_dir;
  logic [NCH-1:0]    rdy;
  logic [NCH-1:0]    gnt;
  logic [SELW-1:0]   gnt_idx;
  logic [SELW-1:0]   sel;
  logic              xfer;
  logic              adv;
  logic [WIDTH-1:0]  sel_data;

  logic              out_valid_q, out_valid_d;
  logic [WIDTH-1:0]  out_data_q,  out_data_d;
  logic [SELW-1:0]   out_ch_q,    out_ch_d;

  rr_arbiter #(.NCH(NCH)) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_i     (bus.in_valid),
    .adv_i     (adv),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx)
  );

  always_comb begin
    load = !out_valid_q || bus.out_ready;

    // An out-of-range index matches no channel, so nothing is offered.
    rdy_dir = '0;
    for (int k = 0; k < NCH; k++) rdy_dir[k] = (bus.ch == SELW'(k));

    if (bus.mode == MODE_RR) begin
      rdy = gnt & {NCH{load}};
      sel = gnt_idx;
    end else begin
      rdy = rdy_dir & {NCH{load}};
      sel = bus.ch;
    end

    xfer = |(rdy & bus.in_valid);
    adv  = xfer && (bus.mode == MODE_RR);

    sel_data = '0;
    for (int k = 0; k < NCH; k++) begin
      if (sel == SELW'(k)) sel_data = bus.in_data[k*WIDTH +: WIDTH];
    end

    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = sel_data;
      out_ch_d    = sel;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Output register stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
    end
  end

  assign bus.in_ready  = rdy;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_ch    = out_ch_q;

endmodule
